// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port req/gnt arbiter that serialises one-word accesses onto a single-port memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; the default build gives port 1 fixed priority.

module mem_arbiter #(
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              memread,
   output logic              memwrite,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] writedata,
   input  logic [DATA_W-1:0] memdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_e;

   state_e              state_q;
   logic [1:0]          cnt_q;
   logic                port_q;
   logic                p0_gnt_q, p1_gnt_q;
   logic                p0_rvalid_q, p1_rvalid_q;
   logic [DATA_W-1:0]   p0_rdata_q, p1_rdata_q;
   logic                memread_q, memwrite_q;
   logic [ADDR_W-1:0]   address_q;
   logic [DATA_W-1:0]   writedata_q;
   logic                busy_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                last_q;
`endif

   logic                win_d;
   logic                sel_we_d;
   logic [ADDR_W-1:0]   sel_addr_d;
   logic [DATA_W-1:0]   sel_wdata_d;

   always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // last_q is the most recently granted port; the other one wins a tie
      win_d = (p0_req && p1_req) ? ~last_q : p1_req;
`else
      win_d = p1_req;
`endif
      sel_we_d    = win_d ? p1_we    : p0_we;
      sel_addr_d  = win_d ? p1_addr  : p0_addr;
      sel_wdata_d = win_d ? p1_wdata : p0_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         port_q      <= 1'b0;
         p0_gnt_q    <= 1'b0;
         p1_gnt_q    <= 1'b0;
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
         memread_q   <= 1'b0;
         memwrite_q  <= 1'b0;
         address_q   <= '0;
         writedata_q <= '0;
         busy_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_q      <= 1'b1;
`endif
      end else begin
         p0_gnt_q    <= 1'b0;
         p1_gnt_q    <= 1'b0;
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
         memread_q   <= 1'b0;
         memwrite_q  <= 1'b0;
         address_q   <= '0;
         writedata_q <= '0;

         case (state_q)
            S_IDLE: begin
               if (p0_req || p1_req) begin
                  state_q   <= S_ISSUE;
                  busy_q    <= 1'b1;
                  port_q    <= win_d;
                  address_q <= sel_addr_d;
                  if (win_d) p1_gnt_q <= 1'b1;
                  else       p0_gnt_q <= 1'b1;
                  if (sel_we_d) begin
                     memwrite_q  <= 1'b1;
                     writedata_q <= sel_wdata_d;
                  end else begin
                     memread_q <= 1'b1;
                  end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_q <= win_d;
`endif
               end
            end

            S_ISSUE: begin
               // the registered strobe doubles as the latched write-enable
               if (memwrite_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_WAIT;
                  cnt_q   <= 2'(MEM_LAT - 1);
               end
            end

            S_WAIT: begin
               if (cnt_q == '0) begin
                  if (port_q) begin
                     p1_rdata_q  <= memdata;
                     p1_rvalid_q <= 1'b1;
                  end else begin
                     p0_rdata_q  <= memdata;
                     p0_rvalid_q <= 1'b1;
                  end
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign p0_gnt    = p0_gnt_q;
   assign p1_gnt    = p1_gnt_q;
   assign p0_rvalid = p0_rvalid_q;
   assign p1_rvalid = p1_rvalid_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rdata  = p1_rdata_q;
   assign memread   = memread_q;
   assign memwrite  = memwrite_q;
   assign address   = address_q;
   assign writedata = writedata_q;
   assign busy      = busy_q;

endmodule
